adc_axi_burst_writer: RTL

- AXI4 write master feeding DDR3 memory from the ADC capture path; the write-initiator end of the controller's 32-bit AXI slave port.
- Buffers incoming 32-bit packed ADC words and issues fixed-length INCR write bursts into a ring region of DDR3.
- Provides a start/stop control and status interface for the capture sequencer/software.

---
 rtl/adc_capture_pkg.sv | 17 +
 rtl/sync_fifo.sv | 58 +++++
 rtl/adc_axi_burst_writer.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/adc_capture_pkg.sv
// rtl/adc_capture_pkg.sv - shared types and AXI constants for the ADC capture writer
package adc_capture_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_DATA,
    ST_ADDR,
    ST_DATA,
    ST_RESP
  } state_t;

  localparam logic [2:0] AXSIZE_4B   = 3'b010;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [3:0] AWCACHE_BUF = 4'b0011;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - first-word-fall-through synchronous FIFO with occupancy count
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  // Head of the queue is always visible so the consumer sees data without a read latency.
  assign rd_data = mem[rd_ptr];

  // Storage array; contents need no reset since pointers define validity.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  // Pointer and occupancy tracking; clear empties the queue in one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/adc_axi_burst_writer.sv
// rtl/adc_axi_burst_writer.sv - AXI4 INCR burst writer streaming ADC words into a DDR3 ring
module adc_axi_burst_writer
  import adc_capture_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'hA4000000,
  parameter logic [31:0] RING_BYTES = 32'h00100000,
  parameter int          BURST_LEN  = 16,
  parameter int          FIFO_DEPTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ctrl_start,
  input  logic        ctrl_stop,
  input  logic [15:0] cfg_num_bursts,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  output logic        stat_busy,
  output logic        stat_done,
  output logic        stat_overflow,
  output logic        stat_resp_err,
  output logic [15:0] stat_burst_cnt,
  output logic        m_axi_awid,
  output logic [31:0] m_axi_awaddr,
  output logic [7:0]  m_axi_awlen,
  output logic [2:0]  m_axi_awsize,
  output logic [1:0]  m_axi_awburst,
  output logic        m_axi_awlock,
  output logic [3:0]  m_axi_awcache,
  output logic [2:0]  m_axi_awprot,
  output logic [3:0]  m_axi_awqos,
  output logic        m_axi_awvalid,
  input  logic        m_axi_awready,
  output logic [31:0] m_axi_wdata,
  output logic [3:0]  m_axi_wstrb,
  output logic        m_axi_wlast,
  output logic        m_axi_wvalid,
  input  logic        m_axi_wready,
  input  logic        m_axi_bid,
  input  logic [1:0]  m_axi_bresp,
  input  logic        m_axi_bvalid,
  output logic        m_axi_bready
);

  localparam int          CW          = $clog2(FIFO_DEPTH);
  localparam logic [31:0] BURST_BYTES = 32'(BURST_LEN * 4);
  localparam logic [7:0]  LAST_BEAT   = 8'(BURST_LEN - 1);
  localparam logic [CW:0] BURST_WORDS = (CW+1)'(BURST_LEN);

  state_t      state;
  state_t      next_state;
  logic [CW:0] fifo_count;
  logic        fifo_full;
  logic        fifo_empty;
  logic        fifo_wr;
  logic        fifo_rd;
  logic        start_go;
  logic        b_fire;
  logic        last_beat;
  logic        target_hit;
  logic        stop_pending;
  logic [7:0]  beat_cnt;
  logic        unused_inputs;

  assign m_axi_awid    = 1'b0;
  assign m_axi_awlen   = LAST_BEAT;
  assign m_axi_awsize  = AXSIZE_4B;
  assign m_axi_awburst = BURST_INCR;
  assign m_axi_awlock  = 1'b0;
  assign m_axi_awcache = AWCACHE_BUF;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_awqos   = 4'b0000;
  assign m_axi_wstrb   = 4'hF;
  assign unused_inputs = ^{m_axi_bid, fifo_empty};

  assign stat_busy  = (state != ST_IDLE);
  assign start_go   = (state == ST_IDLE) && ctrl_start;
  assign fifo_wr    = in_valid && stat_busy;
  assign fifo_rd    = (state == ST_DATA) && m_axi_wready;
  assign b_fire     = (state == ST_RESP) && m_axi_bvalid;
  assign last_beat  = (beat_cnt == LAST_BEAT);
  assign target_hit = (cfg_num_bursts != 16'd0) && (stat_burst_cnt + 16'd1 == cfg_num_bursts);

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clr     (start_go),
    .wr_en   (fifo_wr),
    .wr_data (in_data),
    .rd_en   (fifo_rd),
    .rd_data (m_axi_wdata),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  // Next-state and AXI handshake outputs; a burst is only started once the FIFO holds all of it.
  always_comb begin
    next_state    = state;
    m_axi_awvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    m_axi_wlast   = 1'b0;
    m_axi_bready  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (ctrl_start) next_state = ST_WAIT_DATA;
      end
      ST_WAIT_DATA: begin
        if (ctrl_stop)                       next_state = ST_IDLE;
        else if (fifo_count >= BURST_WORDS)  next_state = ST_ADDR;
      end
      ST_ADDR: begin
        m_axi_awvalid = 1'b1;
        if (m_axi_awready) next_state = ST_DATA;
      end
      ST_DATA: begin
        m_axi_wvalid = 1'b1;
        m_axi_wlast  = last_beat;
        if (m_axi_wready && last_beat) next_state = ST_RESP;
      end
      ST_RESP: begin
        m_axi_bready = 1'b1;
        if (m_axi_bvalid) next_state = (stop_pending || target_hit) ? ST_IDLE : ST_WAIT_DATA;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Address ring, beat counter, stop latch and sticky status.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_axi_awaddr   <= BASE_ADDR;
      beat_cnt       <= 8'd0;
      stop_pending   <= 1'b0;
      stat_done      <= 1'b0;
      stat_overflow  <= 1'b0;
      stat_resp_err  <= 1'b0;
      stat_burst_cnt <= 16'd0;
    end else if (start_go) begin
      m_axi_awaddr   <= BASE_ADDR;
      beat_cnt       <= 8'd0;
      stop_pending   <= 1'b0;
      stat_done      <= 1'b0;
      stat_overflow  <= 1'b0;
      stat_resp_err  <= 1'b0;
      stat_burst_cnt <= 16'd0;
    end else begin
      if (fifo_wr && fifo_full) stat_overflow <= 1'b1;
      if (ctrl_stop && (state == ST_ADDR || state == ST_DATA || state == ST_RESP))
        stop_pending <= 1'b1;
      if (fifo_rd) beat_cnt <= last_beat ? 8'd0 : beat_cnt + 8'd1;
      if (b_fire) begin
        if (m_axi_bresp != RESP_OKAY) stat_resp_err <= 1'b1;
        stat_burst_cnt <= stat_burst_cnt + 16'd1;
        m_axi_awaddr   <= BASE_ADDR + ((m_axi_awaddr - BASE_ADDR + BURST_BYTES) & (RING_BYTES - 32'd1));
        if (target_hit) stat_done <= 1'b1;
        if (stop_pending || target_hit) stop_pending <= 1'b0;
      end
    end
  end

endmodule
